// File: rtl/mat_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mat_add_pkg
// Purpose  : Shared state encodings and size helpers for the matrix-add sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mat_add_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CALC = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int row_size(input int data_len, input int k);
        return data_len * k;
    endfunction

    function automatic int mat_size(input int data_len, input int k, input int m);
        return data_len * k * m;
    endfunction

    // A single-row matrix still needs a 1-bit counter to keep the ports legal.
    function automatic int cnt_width(input int m);
        return (m > 1) ? clog2(m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mat_row_buf.sv
`default_nettype none
// ============================================================================
// Module   : mat_row_buf
// Purpose  : M x ROW_SIZE register file, row-indexed write or full-matrix load,
//            flat read-out of every row.
// Revision : 1.0 - initial release
// ============================================================================
module mat_row_buf
    import mat_add_pkg::*;
#(
    parameter int ROW_SIZE = 256,
    parameter int M        = 8,
    parameter int IDX_W    = 3,
    localparam int MAT_SIZE = ROW_SIZE * M
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr_en,
    input  logic [IDX_W-1:0]    i_wr_row,
    input  logic [ROW_SIZE-1:0] i_wr_data,
    input  logic                i_load_en,
    input  logic [MAT_SIZE-1:0] i_load_data,
    output logic [MAT_SIZE-1:0] o_mat
);

    logic [ROW_SIZE-1:0] rows_q [M];

    // Full load wins over a row write; the sequencer never requests both.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rows_q <= '{default: '0};
        end else begin
            for (int r = 0; r < M; r++) begin
                if (i_load_en) begin
                    rows_q[r] <= i_load_data[ROW_SIZE*r +: ROW_SIZE];
                end else if (i_wr_en && (i_wr_row == IDX_W'(r))) begin
                    rows_q[r] <= i_wr_data;
                end
            end
        end
    end

    genvar gr;
    generate
        for (gr = 0; gr < M; gr++) begin : g_out_row
            assign o_mat[ROW_SIZE*gr +: ROW_SIZE] = rows_q[gr];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mat_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : mat_add_seq
// Purpose  : Row-serial load / capture / stream sequencer around a flat
//            combinational matrix adder. Optional macro MAT_ADD_SEQ_OVF_EN
//            adds a sticky signed-overflow flag output o_ovf.
// Revision : 1.0 - initial release
// ============================================================================
module mat_add_seq
    import mat_add_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int M        = 8,
    parameter int K        = 8,
    localparam int ROW_SIZE = row_size(DATA_LEN, K),
    localparam int MAT_SIZE = mat_size(DATA_LEN, K, M),
    localparam int CNT_W    = cnt_width(M)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_row_valid,
    output logic                o_row_ready,
    input  logic [ROW_SIZE-1:0] i_row_a,
    input  logic [ROW_SIZE-1:0] i_row_b,
    output logic [MAT_SIZE-1:0] o_mat_add_a,
    output logic [MAT_SIZE-1:0] o_mat_add_b,
    input  logic [MAT_SIZE-1:0] i_mat_add_c,
    output logic                o_row_valid,
    input  logic                i_row_ready,
    output logic [ROW_SIZE-1:0] o_row_c,
    output logic                o_busy,
    output logic                o_done
`ifdef MAT_ADD_SEQ_OVF_EN
    ,
    output logic                o_ovf
`endif
);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               row_ready_q;
    logic               row_valid_q;
    logic               busy_q;
    logic               done_q;

    logic               w_in_acc;
    logic               w_out_acc;
    logic               w_cnt_last;
    logic               w_calc;
    logic [MAT_SIZE-1:0] w_mat_c;
    logic [ROW_SIZE-1:0] w_c_rows [M];

    assign w_in_acc   = row_ready_q & i_row_valid;
    assign w_out_acc  = row_valid_q & i_row_ready;
    assign cnt_d      = cnt_q + 1'b1;
    assign w_cnt_last = (cnt_q == CNT_W'(M - 1));
    assign w_calc     = (state_q == ST_CALC);

    // Handshake outputs are flops so neither side sees a combinational path back.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            row_ready_q <= 1'b0;
            row_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q     <= ST_LOAD;
                        cnt_q       <= '0;
                        row_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_in_acc) begin
                        if (w_cnt_last) begin
                            state_q     <= ST_CALC;
                            cnt_q       <= '0;
                            row_ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                ST_CALC: begin
                    state_q     <= ST_SEND;
                    row_valid_q <= 1'b1;
                end
                ST_SEND: begin
                    if (w_out_acc) begin
                        if (w_cnt_last) begin
                            state_q     <= ST_DONE;
                            cnt_q       <= '0;
                            row_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    row_ready_q <= 1'b0;
                    row_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    mat_row_buf #(
        .ROW_SIZE (ROW_SIZE),
        .M        (M),
        .IDX_W    (CNT_W)
    ) u_buf_a (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wr_en     (w_in_acc),
        .i_wr_row    (cnt_q),
        .i_wr_data   (i_row_a),
        .i_load_en   (1'b0),
        .i_load_data ({MAT_SIZE{1'b0}}),
        .o_mat       (o_mat_add_a)
    );

    mat_row_buf #(
        .ROW_SIZE (ROW_SIZE),
        .M        (M),
        .IDX_W    (CNT_W)
    ) u_buf_b (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wr_en     (w_in_acc),
        .i_wr_row    (cnt_q),
        .i_wr_data   (i_row_b),
        .i_load_en   (1'b0),
        .i_load_data ({MAT_SIZE{1'b0}}),
        .o_mat       (o_mat_add_b)
    );

    mat_row_buf #(
        .ROW_SIZE (ROW_SIZE),
        .M        (M),
        .IDX_W    (CNT_W)
    ) u_buf_c (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wr_en     (1'b0),
        .i_wr_row    ({CNT_W{1'b0}}),
        .i_wr_data   ({ROW_SIZE{1'b0}}),
        .i_load_en   (w_calc),
        .i_load_data (i_mat_add_c),
        .o_mat       (w_mat_c)
    );

    genvar gr;
    generate
        for (gr = 0; gr < M; gr++) begin : g_c_row
            assign w_c_rows[gr] = w_mat_c[ROW_SIZE*gr +: ROW_SIZE];
        end
    endgenerate

    assign o_row_c     = w_c_rows[cnt_q];
    assign o_row_ready = row_ready_q;
    assign o_row_valid = row_valid_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

`ifdef MAT_ADD_SEQ_OVF_EN
    logic           ovf_q;
    logic [M*K-1:0] w_ovf_el;

    // Signed overflow: operands agree in sign but the wrapped sum does not.
    genvar ge;
    generate
        for (ge = 0; ge < M*K; ge++) begin : g_ovf_el
            assign w_ovf_el[ge] =
                (o_mat_add_a[DATA_LEN*ge + DATA_LEN - 1] == o_mat_add_b[DATA_LEN*ge + DATA_LEN - 1]) &&
                (i_mat_add_c[DATA_LEN*ge + DATA_LEN - 1] != o_mat_add_a[DATA_LEN*ge + DATA_LEN - 1]);
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && i_start) begin
            ovf_q <= 1'b0;
        end else if (w_calc && (|w_ovf_el)) begin
            ovf_q <= 1'b1;
        end
    end

    assign o_ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mat_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mat_add_seq
// Purpose  : Directed-vector bench for mat_add_seq with a behavioural adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mat_add_seq;

    localparam int DL = 32;
    localparam int M  = 8;
    localparam int K  = 8;
    localparam int RS = DL * K;
    localparam int MS = RS * M;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [RS-1:0] row_a;
    logic [RS-1:0] row_b;
    logic [MS-1:0] mat_a;
    logic [MS-1:0] mat_b;
    logic [MS-1:0] mat_c;
    logic          out_valid;
    logic          out_ready;
    logic [RS-1:0] row_c;
    logic          busy;
    logic          done;
`ifdef MAT_ADD_SEQ_OVF_EN
    logic          ovf;
`endif

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stand-in for the external combinational adder.
    always_comb begin
        mat_c = '0;
        for (int e = 0; e < M*K; e++) begin
            mat_c[DL*e +: DL] = mat_a[DL*e +: DL] + mat_b[DL*e +: DL];
        end
    end

    mat_add_seq #(.DATA_LEN(DL), .M(M), .K(K)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_row_valid (in_valid),
        .o_row_ready (in_ready),
        .i_row_a     (row_a),
        .i_row_b     (row_b),
        .o_mat_add_a (mat_a),
        .o_mat_add_b (mat_b),
        .i_mat_add_c (mat_c),
        .o_row_valid (out_valid),
        .i_row_ready (out_ready),
        .o_row_c     (row_c),
        .o_busy      (busy),
        .o_done      (done)
`ifdef MAT_ADD_SEQ_OVF_EN
        ,
        .o_ovf       (ovf)
`endif
    );

    typedef struct {
        logic [31:0] a_base;
        logic [31:0] a_rs;
        logic [31:0] a_es;
        logic [31:0] b_val;
        logic [31:0] c_base;
        logic        ovf;
        bit          gaps;
        int          stall_row;
        bit          start_in_send;
        bit          check_lat;
    } vec_t;

    vec_t vecs [5];

    task automatic chk_row(input string name, input logic [RS-1:0] act, input logic [RS-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [RS-1:0] mk_row(input logic [31:0] base, input logic [31:0] rs,
                                             input logic [31:0] es, input int r);
        logic [RS-1:0] v;
        v = '0;
        for (int i = 0; i < K; i++) begin
            v[DL*i +: DL] = base + 32'(r) * rs + 32'(i) * es;
        end
        return v;
    endfunction

    task automatic load_rows(input vec_t v, input int nrows);
        int n;
        for (int r = 0; r < nrows; r++) begin
            if (v.gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            in_valid = 1'b1;
            row_a = mk_row(v.a_base, v.a_rs, v.a_es, r);
            row_b = mk_row(v.b_val, 32'd0, 32'd0, r);
            n = 0;
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) chk_bit($sformatf("row_ready timeout row%0d", r), in_ready, 1'b1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int cs;
        int n;
        logic [RS-1:0] exp;
        @(negedge clk);
        start = 1'b1;
        cs = cyc;
        @(negedge clk);
        start = 1'b0;
        load_rows(v, M);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk_bit({tag, " row_valid timeout"}, out_valid, 1'b1);
            return;
        end
        for (int r = 0; r < M; r++) begin
            exp = mk_row(v.c_base, v.a_rs, v.a_es, r);
            chk_row($sformatf("%s row%0d", tag, r), row_c, exp);
            if (v.check_lat && r == 3) begin
                chk_int({tag, " r3e5"}, int'(row_c[DL*5 +: DL]), 129);
            end
            if (r == v.stall_row) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk_row($sformatf("%s stall row%0d", tag, r), row_c, exp);
                end
                out_ready = 1'b1;
            end
            if (v.start_in_send && r == 2) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        chk_bit({tag, " done"}, done, 1'b1);
        if (v.check_lat) chk_int({tag, " latency"}, cyc - cs + 1, 2*M + 3);
`ifdef MAT_ADD_SEQ_OVF_EN
        chk_bit({tag, " ovf"}, ovf, v.ovf);
`endif
        chk_row({tag, " hold a row7"}, mat_a[RS*7 +: RS], mk_row(v.a_base, v.a_rs, v.a_es, 7));
        @(negedge clk);
        chk_bit({tag, " done pulse"}, done, 1'b0);
        chk_bit({tag, " idle busy"}, busy, 1'b0);
        @(negedge clk);
        chk_bit({tag, " idle ready"}, in_ready, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_bit({tag, " row_ready"}, in_ready, 1'b0);
        chk_bit({tag, " row_valid"}, out_valid, 1'b0);
        chk_row({tag, " row_c"}, row_c, '0);
        chk_bit({tag, " mat_a nz"}, |mat_a, 1'b0);
        chk_bit({tag, " mat_b nz"}, |mat_b, 1'b0);
        chk_bit({tag, " busy"}, busy, 1'b0);
        chk_bit({tag, " done"}, done, 1'b0);
`ifdef MAT_ADD_SEQ_OVF_EN
        chk_bit({tag, " ovf"}, ovf, 1'b0);
`endif
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 32'd8,  32'd1, 32'd100,      32'd100,      1'b0, 1'b0, -1, 1'b0, 1'b1};
        vecs[1] = '{32'h7FFF_FFFF, 32'd0,  32'd0, 32'd1,        32'h8000_0000, 1'b1, 1'b0, -1, 1'b0, 1'b0};
        vecs[2] = '{32'd5,         32'd0,  32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 1'b0, -1, 1'b0, 1'b0};
        vecs[3] = '{32'hFFFF_0000, 32'h10, 32'd1, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b1,  4, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'd0,  32'd0, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, -1, 1'b1, 1'b0};

        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        row_a     = '0;
        row_b     = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_job(vecs[v], $sformatf("vec%0d", v));
        end

        // Reset in the middle of loading discards the partial job.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load_rows(vecs[1], 5);
        chk_bit("midjob busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk_all_zero("midjob reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_bit("post reset ready", in_ready, 1'b0);
        chk_bit("post reset busy", busy, 1'b0);

        run_job(vecs[0], "fresh");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mat_add_seq.md
# mat_add_seq

Row-serial sequencer for the combinational matrix adder. Accepts matrices A and B one row per handshake, holds them in registers that drive the adder's flat matrix inputs, captures the flat sum once, then streams C out one row per handshake. Sits between a row-oriented producer/consumer (DMA or testbench) and the wide `mat_add` datapath, so no client has to drive MAT_SIZE-bit buses.

## Interface
- DATA_LEN, 32, signed element width
- M, 8, rows per matrix
- K, 8, elements per row (C is M×K)
- ROW_SIZE, DATA_LEN*K, derived, flat row width
- MAT_SIZE, DATA_LEN*K*M, derived, flat matrix width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  job start pulse; sampled only in IDLE
- i_row_valid  in  1  input row valid
- o_row_ready  out  1  input row ready
- i_row_a  in  ROW_SIZE  row of A; element i at bits [DATA_LEN*i +: DATA_LEN]
- i_row_b  in  ROW_SIZE  row of B; same packing
- o_mat_add_a  out  MAT_SIZE  to adder; row r at [ROW_SIZE*r +: ROW_SIZE]
- o_mat_add_b  out  MAT_SIZE  to adder; same packing
- i_mat_add_c  in  MAT_SIZE  from adder
- o_row_valid  out  1  output row valid
- i_row_ready  in  1  output row ready
- o_row_c  out  ROW_SIZE  row of C
- o_busy  out  1  high in any state but IDLE
- o_done  out  1  one-cycle pulse, job complete

## Operation
- States: IDLE, LOAD, CALC, SEND, DONE. A 3-bit state register and a row counter `cnt` (clog2(M) bits).
- IDLE: `o_row_ready`=0, `o_row_valid`=0. `i_start`=1 → LOAD, `cnt`=0.
- LOAD: `o_row_ready`=1. On `i_row_valid && o_row_ready`, write `i_row_a`/`i_row_b` into row `cnt` of the A/B registers, then `cnt`++. An accept at `cnt`==M-1 → CALC, `cnt`=0.
- CALC: one cycle. `o_row_ready`=0. Register `i_mat_add_c` into the C register → SEND.
- SEND: `o_row_valid`=1, `o_row_c` = C row `cnt`. On `o_row_valid && i_row_ready`, `cnt`++. An accept at `cnt`==M-1 → DONE.
- DONE: `o_done`=1 for one cycle → IDLE.
- `o_mat_add_a`/`o_mat_add_b` are driven continuously from the A/B registers. They hold their values after the job until the next LOAD writes over them.
- Arithmetic is done in the external adder: two's-complement, wraps modulo 2^DATA_LEN, no widening.
- `i_start` outside IDLE is ignored. It is not queued.
- Rows are strictly in order 0..M-1. There is no row addressing.

## Timing
- Reset (asynchronous, takes effect immediately): state=IDLE, `cnt`=0, A/B/C registers=0. All outputs are 0: `o_row_ready`, `o_row_valid`, `o_row_c`, `o_mat_add_a`, `o_mat_add_b`, `o_busy`, `o_done`.
- Reset mid-job discards all loaded rows. After release, the block waits in IDLE for a new `i_start`.
- `i_start` high at edge t → LOAD from t+1.
- Latency with no stalls: last input accept at edge t → CALC during t+1 → first `o_row_valid` at t+2 → last output accept at t+2+M-1 → `o_done` high in the following cycle.
- Minimum job length: 2M+3 cycles from `i_start` to `o_done`.
- Backpressure: while `o_row_valid && !i_row_ready`, `o_row_c` and `cnt` hold stable. `i_row_valid` may drop between rows without loss.
- `o_row_valid` never depends combinationally on `i_row_ready`. `o_row_ready` never depends combinationally on `i_row_valid`.

## Configuration
- Macro: `MAT_ADD_SEQ_OVF_EN`.
- Defined: adds output `o_ovf` (1 bit), cleared on `i_start` accept and on reset. In CALC, it is set if any element has sign(a)==sign(b) and sign(c)≠sign(a). It holds until the next job.
- Undefined: no `o_ovf` port and no overflow logic.

## Structure
- Shared package/header `mat_add_pkg`:
  - state encodings ST_IDLE..ST_DONE
  - ROW_SIZE/MAT_SIZE derivation
  - clog2 function
- Sub-module `mat_row_buf`: M×ROW_SIZE register with row-indexed write, flat MAT_SIZE read, async reset. It is instantiated for A, B and C.
  - For C, every row is written in the same cycle, using a full-load enable.

## Test plan
- M=K=8, DATA_LEN=32. A[r][i]=r*8+i, B[r][i]=100. Out row 3 element 5 = 129. `o_done` arrives 19 cycles after `i_start` with no stalls.
- A all 32'h7FFFFFFF, B all 1 → every C element is 32'h80000000. With `MAT_ADD_SEQ_OVF_EN` defined, `o_ovf`=1. A all 5, B all -7 → C all -2 and `o_ovf`=0.
- Random `i_row_valid` gaps, plus `i_row_ready` low for 3 cycles on row 4 → `o_row_c` stable during the stall, all 8 rows correct and in order.
- `i_start` pulsed during SEND → ignored. `o_done` is exactly one pulse. A second `i_start` after DONE runs a fresh job correctly.
- Assert `i_rst` after 5 rows are loaded → all outputs 0 immediately. After release, the block is in IDLE and `o_row_ready`=0 until `i_start`.
